// File: rtl/block_mem_responder.sv
// Block-burst memory responder: serves whole-block reads/writes from an internal word-addressed RAM.
// Optional pre-burst wait state enabled by defining BLOCK_MEM_WAIT_EN.
module block_mem_responder #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned ADDR_WIDTH         = 16,
  parameter int unsigned BLOCK_OFFSET_WIDTH = 5,
  parameter int unsigned WAIT_CYCLES        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_req_op,
  input  logic                  mem_rw,
  output logic [DATA_WIDTH-1:0] mem_read,
  output logic                  mem_read_valid,
  input  logic [DATA_WIDTH-1:0] mem_write,
  output logic                  mem_write_req,
  output logic                  mem_last,
  output logic                  ready
);

`ifdef BLOCK_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam int unsigned BLOCK_SIZE = 1 << BLOCK_OFFSET_WIDTH;
  localparam int unsigned CW         = BLOCK_OFFSET_WIDTH + 1;
  localparam int unsigned EFF_WAIT   = WAIT_EN ? WAIT_CYCLES : 0;
  localparam int unsigned WW         = $clog2(EFF_WAIT + 2);

  localparam logic [CW-1:0]         CNT_LAST  = CW'(BLOCK_SIZE - 1);
  localparam logic [CW-1:0]         CNT_DONE  = CW'(BLOCK_SIZE);
  localparam logic [WW-1:0]         WAIT_LAST = WW'((EFF_WAIT > 0) ? EFF_WAIT - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BLOCK_SIZE - 1);

  // WAIT is only reachable when the wait feature is compiled in.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    WRITE
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] base;
  logic                  rw;
  logic [CW-1:0]         cnt;
  logic [WW-1:0]         wait_cnt;
  logic                  rd_v1, rd_last1;
  logic                  issue, wr_en, wr_last_n;
  logic [CW-1:0]         wr_cnt_n;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

  assign ready    = (state == IDLE);
  assign ram_addr = base | ADDR_WIDTH'(cnt[BLOCK_OFFSET_WIDTH-1:0]);
  assign issue    = (state == READ) && (cnt <= CNT_LAST);
  assign wr_en    = (state == WRITE) && mem_write_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (mem_req_op) state_n = (EFF_WAIT > 0) ? WAIT : (mem_rw ? WRITE : READ);
      WAIT:    if (wait_cnt == WAIT_LAST) state_n = rw ? WRITE : READ;
      READ:    if (cnt == CNT_DONE) state_n = IDLE;
      WRITE:   if (mem_write_req && (cnt == CNT_LAST)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The first WRITE cycle is a setup cycle; requests start one edge later.
  always_comb begin
    wr_cnt_n  = mem_write_req ? cnt + 1'b1 : cnt;
    wr_last_n = (state == WRITE) && (state_n == WRITE) && (wr_cnt_n == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base           <= '0;
      rw             <= 1'b0;
      cnt            <= '0;
      wait_cnt       <= '0;
      rd_v1          <= 1'b0;
      rd_last1       <= 1'b0;
      mem_read       <= '0;
      mem_read_valid <= 1'b0;
      mem_write_req  <= 1'b0;
      mem_last       <= 1'b0;
    end else begin
      rd_v1          <= issue;
      rd_last1       <= issue && (cnt == CNT_LAST);
      mem_read_valid <= rd_v1;
      mem_read       <= rd_v1 ? ram_q : '0;
      mem_write_req  <= (state == WRITE) && (state_n == WRITE);
      mem_last       <= rd_last1 | wr_last_n;
      case (state)
        IDLE: begin
          if (mem_req_op) begin
            base     <= mem_addr & ~OFF_MASK;
            rw       <= mem_rw;
            cnt      <= '0;
            wait_cnt <= '0;
          end
        end
        WAIT:    wait_cnt <= wait_cnt + 1'b1;
        READ:    cnt <= cnt + 1'b1;
        WRITE:   cnt <= wr_cnt_n;
        default: ;
      endcase
    end
  end

  // Plain synchronous RAM, no reset, one-cycle read latency.
  always_ff @(posedge clk) begin
    if (wr_en) ram[ram_addr] <= mem_write;
    ram_q <= ram[ram_addr];
  end

endmodule

// File: tb/tb_block_mem_responder.sv
// Self-checking bench for block_mem_responder: directed block scenarios plus random
// transactions checked cycle by cycle against a word-array memory model.
module tb_block_mem_responder;

`ifdef BLOCK_MEM_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif
  localparam int BS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_req_op;
  logic        mem_rw;
  logic [31:0] mem_read;
  logic        mem_read_valid;
  logic [31:0] mem_write;
  logic        mem_write_req;
  logic        mem_last;
  logic        ready;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [31:0] model [int unsigned];
  logic [31:0] wdata [BS];
  logic [15:0] blocks [$];

  block_mem_responder #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .BLOCK_OFFSET_WIDTH(5),
    .WAIT_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr(mem_addr),
    .mem_req_op(mem_req_op),
    .mem_rw(mem_rw),
    .mem_read(mem_read),
    .mem_read_valid(mem_read_valid),
    .mem_write(mem_write),
    .mem_write_req(mem_write_req),
    .mem_last(mem_last),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called at a negedge while idle; returns at the negedge where ready is back.
  task automatic do_write(input logic [15:0] addr);
    logic [15:0] base;
    int beat;
    logic in_burst;
    base = addr & 16'hFFE0;
    chk("wr_start_ready", {31'b0, ready}, 32'd1);
    mem_req_op = 1'b1;
    mem_addr   = addr;
    mem_rw     = 1'b1;
    for (int n = 0; n <= 33 + W; n++) begin
      @(negedge clk);
      if (n == 0) begin
        mem_req_op = 1'b0;
        mem_addr   = 16'($urandom);
        mem_rw     = 1'($urandom);
      end
      beat     = n - 1 - W;
      in_burst = (beat >= 0) && (beat < BS);
      chk($sformatf("wr_req@%0d", n), {31'b0, mem_write_req}, {31'b0, in_burst});
      chk($sformatf("wr_last@%0d", n), {31'b0, mem_last}, {31'b0, beat == BS - 1});
      chk($sformatf("wr_ready@%0d", n), {31'b0, ready}, {31'b0, n == 33 + W});
      chk($sformatf("wr_rvalid@%0d", n), {31'b0, mem_read_valid}, 32'd0);
      if (in_burst) begin
        mem_write = wdata[beat];
        model[int'(base) + beat] = wdata[beat];
      end else begin
        mem_write = $urandom;
      end
    end
  endtask

  // busy_at / rst_at: beat index at which to inject a request or a reset (-1 = none).
  task automatic do_read(input logic [15:0] addr, input int busy_at, input int rst_at);
    logic [15:0] base;
    int beat;
    logic vexp;
    int unsigned a;
    base = addr & 16'hFFE0;
    chk("rd_start_ready", {31'b0, ready}, 32'd1);
    mem_req_op = 1'b1;
    mem_addr   = addr;
    mem_rw     = 1'b0;
    for (int n = 0; n <= 33 + W; n++) begin
      @(negedge clk);
      if (n == 0) mem_req_op = 1'b0;
      beat = n - 2 - W;
      vexp = (beat >= 0) && (beat < BS);
      chk($sformatf("rd_valid@%0d", n), {31'b0, mem_read_valid}, {31'b0, vexp});
      chk($sformatf("rd_last@%0d", n), {31'b0, mem_last}, {31'b0, beat == BS - 1});
      chk($sformatf("rd_ready@%0d", n), {31'b0, ready}, {31'b0, n == 33 + W});
      chk($sformatf("rd_wreq@%0d", n), {31'b0, mem_write_req}, 32'd0);
      if (vexp) begin
        a = int'(base) + beat;
        if (model.exists(a)) chk($sformatf("rd_data[%0d]@%04h", beat, base), mem_read, model[a]);
      end
      if (busy_at >= 0 && beat == busy_at) begin
        mem_req_op = 1'b1;
        mem_addr   = 16'h0100;
        mem_rw     = 1'($urandom);
      end else begin
        mem_req_op = 1'b0;
      end
      if (rst_at >= 0 && beat == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_rvalid", {31'b0, mem_read_valid}, 32'd0);
        chk("rst_rdata", mem_read, 32'd0);
        chk("rst_last", {31'b0, mem_last}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle_checks(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("idle_rvalid", {31'b0, mem_read_valid}, 32'd0);
      chk("idle_wreq", {31'b0, mem_write_req}, 32'd0);
      chk("idle_ready", {31'b0, ready}, 32'd1);
    end
  endtask

  initial begin
    logic [15:0] a;
    int gap;
    rst        = 1'b1;
    mem_addr   = '0;
    mem_req_op = 1'b0;
    mem_rw     = 1'b0;
    mem_write  = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, ready}, 32'd1);
    chk("reset_rvalid", {31'b0, mem_read_valid}, 32'd0);
    chk("reset_rdata", mem_read, 32'd0);
    chk("reset_wreq", {31'b0, mem_write_req}, 32'd0);
    chk("reset_last", {31'b0, mem_last}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Round trip at 0x0040, then unaligned read of the same block.
    for (int i = 0; i < BS; i++) wdata[i] = 32'hA500_0000 + 32'(i);
    do_write(16'h0040);
    do_read(16'h0040, -1, -1);
    do_read(16'h0047, -1, -1);

    // Request while busy is ignored.
    do_read(16'h0040, 10, -1);
    idle_checks(4);

    // Reset mid-read, then a clean read.
    do_read(16'h0040, -1, 10);
    do_read(16'h0040, -1, -1);

    // Back-to-back read right after a write.
    for (int i = 0; i < BS; i++) wdata[i] = $urandom;
    do_write(16'h0080);
    do_read(16'h0080, -1, -1);
    blocks.push_back(16'h0040);
    blocks.push_back(16'h0080);

    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 16'($urandom);
        for (int i = 0; i < BS; i++) wdata[i] = $urandom;
        do_write(a);
        blocks.push_back(a & 16'hFFE0);
      end else begin
        a = blocks[$urandom_range(0, blocks.size() - 1)] | 16'($urandom_range(0, 31));
        do_read(a, -1, -1);
      end
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/block_mem_responder.md
# block_mem_responder

Memory-side responder for the data cache's BRAM burst interface. Owns a word-addressed block RAM and serves whole-block transactions: it streams a block to the cache on a read miss and absorbs a block from the cache on a writeback. One transaction is in flight at a time, and every transfer is exactly one cache block. It sits between the data cache's `mem_*` port and the on-chip RAM.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 16: word address width; RAM depth is 2^ADDR_WIDTH words.
- `BLOCK_OFFSET_WIDTH`, 5: log2 of words per block (BLOCK_SIZE = 32).
- `WAIT_CYCLES`, 4: extra pre-burst latency; only used with `BLOCK_MEM_WAIT_EN`.

Ports:
- `clk` in 1: single clock, all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_addr` in ADDR_WIDTH: request word address, sampled on acceptance.
- `mem_req_op` in 1: request strobe.
- `mem_rw` in 1: 0 = block read, 1 = block write, sampled on acceptance.
- `mem_read` out DATA_WIDTH: read beat data.
- `mem_read_valid` out 1: `mem_read` holds a valid beat this cycle.
- `mem_write` in DATA_WIDTH: write beat data, sampled while `mem_write_req` = 1.
- `mem_write_req` out 1: requests/consumes one write word this cycle.
- `mem_last` out 1: final beat of the current burst.
- `ready` out 1: idle; a request is accepted this cycle.

## Operation
- States: IDLE, WAIT (macro only), READ, WRITE.
- IDLE: `ready` = 1. On `mem_req_op` = 1 at a rising edge, latch base = `mem_addr` with low BLOCK_OFFSET_WIDTH bits forced to 0, latch `mem_rw`, clear beat counter. Next state is WAIT if the macro is enabled and WAIT_CYCLES > 0, otherwise READ or WRITE.
- `mem_req_op` is ignored whenever `ready` = 0.
- READ:
  - Issue RAM reads at base+0 … base+BLOCK_SIZE-1 on consecutive cycles.
  - RAM read latency is 1 cycle; beats come out in address order.
  - `mem_read_valid` is high for exactly BLOCK_SIZE contiguous cycles.
  - `mem_last` is high with beat BLOCK_SIZE-1.
- WRITE:
  - `mem_write_req` is high for BLOCK_SIZE contiguous cycles.
  - In each such cycle, `mem_write` is written to base+cnt at the closing edge, then cnt increments.
  - `mem_last` is high with the final request.
- Address arithmetic is modulo 2^BLOCK_OFFSET_WIDTH within a block. A burst never crosses a block boundary.
- The RAM array is not reset.

## Timing
- Acceptance edge = E0.
- Read (no macro): `mem_read_valid` high in cycles after E2 … E(BLOCK_SIZE+1). `mem_last` after E(BLOCK_SIZE+1). `ready` returns 1 in the same cycle as the `mem_last` beat, so a back-to-back request is accepted at the following edge.
- Write (no macro): `mem_write_req` high in cycles after E1 … E(BLOCK_SIZE). `mem_last` after E(BLOCK_SIZE). `ready` = 1 after E(BLOCK_SIZE+1).
- A read issued immediately after a write returns the newly written data (no hazard; the write has completed before `ready`).
- Reset values: `mem_read` = 0, `mem_read_valid` = 0, `mem_write_req` = 0, `mem_last` = 0, state IDLE, `ready` = 1.
- Reset mid-burst: all beat outputs drop to 0 immediately (asynchronously) and the state returns to IDLE. Words already written stay in RAM; the rest of the block is unchanged.
- `mem_read_valid` and `mem_write_req` are never both high.

## Configuration
- `BLOCK_MEM_WAIT_EN` defined: WAIT state inserted after acceptance for WAIT_CYCLES cycles, `ready` = 0 throughout. All beat timings in the Timing section shift later by WAIT_CYCLES.
- Undefined: no WAIT state; WAIT_CYCLES is ignored; timing exactly as listed in the Timing section.

## Test plan
- Block read/write round trip: write burst at 0x0040 with data 0xA5000000+i (i = 0..31), then read 0x0040. Required: 32 contiguous beats returning 0xA5000000+i in order, `mem_last` only on beat 31, first beat after E2.
- Unaligned address: read request at 0x0047 after the round-trip test. Required: serves block 0x0040, beat 0 = 0xA5000000.
- Request while busy: pulse `mem_req_op` with `mem_addr` = 0x0100 during beat 10 of a read. Required: ignored; the current burst completes unchanged and no second burst starts.
- Reset mid-read: assert `rst` during beat 10 of a read. Required: `mem_read_valid` = 0 at once and `ready` = 1; a fresh read of 0x0040 then returns correct data from beat 0.
- Back-to-back: issue a read request in the cycle `ready` rises after a write to 0x0080. Required: it is accepted and returns the written data.
- `BLOCK_MEM_WAIT_EN` with WAIT_CYCLES = 3: read of 0x0040. Required: first `mem_read_valid` after E5, `ready` = 0 during the wait cycles.
